message_encryptor: RTL
======================

// Module: message_encryptor
// PURPOSE
//  Streaming encryptor on the transmit side of the toy public-key cipher, opposite end of the decryptor/key path.
//  Latches an 8-bit public key, then encrypts a plaintext character stream: C = (Pt + Pk) mod P.
//  Sits between the message source and the link toward the decrypting end.
//  Ready/valid on both sides; a NULL_CHAR (8'h00) plaintext terminates the message.
// PARAMETERS
//  P        227  cipher modulus; valid key/plaintext range 1..P-1
//  MAX_LEN  32   max non-terminator chars per message
//  CNT_W    $clog2(MAX_LEN+1)  width of char_count
// PORTS
//  clk              in   1      clock, rising edge
//  rst              in   1      asynchronous, active-high reset
//  mode             in   2      2'b10 = encrypt mode; any other value idles/aborts
//  pk_valid         in   1      public_key is valid this cycle
//  public_key       in   8      public key Pk
//  pt_valid         in   1      plaintext beat valid
//  pt_ready         out  1      encryptor accepts plaintext this cycle
//  plaintext        in   8      plaintext char; 8'h00 = end of message
//  ct_valid         out  1      ciphertext beat valid
//  ct_ready         in   1      downstream accepts ciphertext
//  ciphertext       out  8      encrypted char (0..P-1); 8'h00 on terminator beat
//  ct_last          out  1      marks the terminator beat (qualified by ct_valid)
//  msg_done         out  1      1-cycle pulse: message finished
//  char_count       out  CNT_W  chars encrypted in current message
//  err_invalid_pk   out  1      1-cycle pulse: rejected key
//  err_invalid_pt   out  1      1-cycle pulse: rejected plaintext char
//  checksum         out  8      only with ENC_CHECKSUM_EN, see CONFIGURATION
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; key register 0; ciphertext=8'h00.
//  FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: mode==2'b10 && pk_valid: Pk in 1..P-1 -> latch key, char_count=0, go RUN;
//    else err_invalid_pk pulses the next cycle and the FSM stays in IDLE. pt_ready=0.
//  RUN: pt_ready = (!ct_valid || ct_ready) && char_count<MAX_LEN.
//    Transfer on pt_valid&&pt_ready -> registered result at next cycle (latency 1).
//    Pt in 1..P-1: sum[8:0]=Pt+Pk (2..452); ct = sum>=P ? sum-P : sum; ct_last=0; count++.
//    Pt==8'h00: ct=8'h00, ct_last=1, go DRAIN. Pt>=P: dropped, err_invalid_pt pulses, no ct beat, count held.
//    char_count==MAX_LEN: pt_ready=0; the next accepted-eligible step forces terminator beat (ct=0, ct_last=1), go DRAIN.
//  Output register: ct_valid held with stable data until ct_ready; simultaneous pop+push in the same cycle is allowed.
//  DRAIN: wait for ct_valid&&ct_ready on last beat -> DONE. DONE: msg_done=1 for one cycle -> IDLE.
//  pk_valid ignored outside IDLE; key is stable for the whole message.
//  mode!=2'b10 in RUN/DRAIN: abort next cycle -> IDLE, ct_valid=0, no msg_done, count cleared.
//  Reset mid-message: immediate return to reset values; in-flight beat lost.
// CONFIGURATION
//  ENC_CHECKSUM_EN defined: checksum = (sum of emitted non-terminator ct) mod P.
//    Cleared on key latch; updated on each ct handshake; held after DONE until the next key.
//  Undefined: checksum port absent; no checksum logic.
// TESTING
//  Pk=100; pt 65,200,0 -> ct 165 (last=0), 73 (last=0), 0 (last=1); msg_done 1 cycle after last handshake; count=2.
//  Pk=100; pt=127 -> ct=8'h00 with ct_last=0 (zero result is not the terminator); Pk=0 or 227 -> err_invalid_pk, stays IDLE.
//  Pk=5; pt=230 -> err_invalid_pt pulse, no ct beat, count unchanged; pt=10 -> ct=15.
//  ct_ready=0 for 4 cycles with pt_valid=1 -> pt_ready=0; ct data stable; resume -> no loss, no duplicates.
//  MAX_LEN=32 chars without terminator -> forced ct_last beat after 32nd; pt_ready stays 0.
//  mode->2'b00 mid-RUN -> IDLE next cycle, ct_valid=0, no msg_done; rst pulse mid-msg -> all outputs 0.
//  ENC_CHECKSUM_EN, Pk=100, pt 65,200 -> checksum=(165+73) mod 227=11.

Source files
------------

// File: rtl/message_encryptor.sv
// Streaming encryptor for the toy public-key cipher: latches a public key, then emits C = (Pt + Pk) mod P
// per plaintext char with ready/valid on both sides. Optional running checksum under ENC_CHECKSUM_EN.
module message_encryptor #(
  parameter int P       = 227,
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             pk_valid,
  input  logic [7:0]       public_key,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [7:0]       plaintext,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic [7:0]       ciphertext,
  output logic             ct_last,
  output logic             msg_done,
  output logic [CNT_W-1:0] char_count,
  output logic             err_invalid_pk,
`ifdef ENC_CHECKSUM_EN
  output logic [7:0]       checksum,
`endif
  output logic             err_invalid_pt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t     state;
  logic [7:0] key;
  logic       enc_mode, out_free, pop, key_ok, pt_ok, at_max;
  logic [8:0] sum;
  logic [7:0] ct_next;

  assign enc_mode = (mode == 2'b10);
  assign out_free = !ct_valid || ct_ready;
  assign pop      = ct_valid && ct_ready;
  assign at_max   = (char_count == CNT_W'(MAX_LEN));
  assign key_ok   = (public_key != 8'h00) && ({1'b0, public_key} < 9'(P));
  assign pt_ok    = {1'b0, plaintext} < 9'(P);
  assign sum      = {1'b0, plaintext} + {1'b0, key};
  assign ct_next  = (sum >= 9'(P)) ? 8'(sum - 9'(P)) : sum[7:0];

  // pt_ready looks at ct_ready combinationally so a pop and a push can share one cycle.
  assign pt_ready = (state == RUN) && enc_mode && out_free && !at_max;

`ifdef ENC_CHECKSUM_EN
  logic [8:0] ck_sum;
  assign ck_sum = {1'b0, checksum} + {1'b0, ciphertext};
`endif

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      key            <= 8'h00;
      ct_valid       <= 1'b0;
      ciphertext     <= 8'h00;
      ct_last        <= 1'b0;
      msg_done       <= 1'b0;
      char_count     <= '0;
      err_invalid_pk <= 1'b0;
      err_invalid_pt <= 1'b0;
`ifdef ENC_CHECKSUM_EN
      checksum       <= 8'h00;
`endif
    end else begin
      msg_done       <= 1'b0;
      err_invalid_pk <= 1'b0;
      err_invalid_pt <= 1'b0;
      case (state)
        IDLE: begin
          if (enc_mode && pk_valid) begin
            if (key_ok) begin
              key        <= public_key;
              char_count <= '0;
              state      <= RUN;
`ifdef ENC_CHECKSUM_EN
              checksum   <= 8'h00;
`endif
            end else begin
              err_invalid_pk <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!enc_mode) begin
            state      <= IDLE;
            ct_valid   <= 1'b0;
            ct_last    <= 1'b0;
            char_count <= '0;
          end else begin
            if (pop) begin
              ct_valid <= 1'b0;
`ifdef ENC_CHECKSUM_EN
              checksum <= (ck_sum >= 9'(P)) ? 8'(ck_sum - 9'(P)) : ck_sum[7:0];
`endif
            end
            // A full message closes itself with a terminator once the output slot frees up.
            if (at_max && out_free) begin
              ct_valid   <= 1'b1;
              ciphertext <= 8'h00;
              ct_last    <= 1'b1;
              state      <= DRAIN;
            end else if (pt_valid && pt_ready) begin
              if (plaintext == 8'h00) begin
                ct_valid   <= 1'b1;
                ciphertext <= 8'h00;
                ct_last    <= 1'b1;
                state      <= DRAIN;
              end else if (pt_ok) begin
                ct_valid   <= 1'b1;
                ciphertext <= ct_next;
                ct_last    <= 1'b0;
                char_count <= char_count + CNT_W'(1);
              end else begin
                err_invalid_pt <= 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (!enc_mode) begin
            state      <= IDLE;
            ct_valid   <= 1'b0;
            ct_last    <= 1'b0;
            char_count <= '0;
          end else if (pop) begin
            ct_valid <= 1'b0;
            ct_last  <= 1'b0;
            msg_done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
